// File: rtl/key_schedule_sequencer.sv
// -----------------------------------------------------------------------------
// key_schedule_sequencer
//   Iterative AES key expansion. One 32-bit schedule word is produced per
//   clock through a single SubWord/RotWord/Rcon datapath. All 4*(Nr+1) words
//   are kept in an internal store that the round controllers read by index.
//
// Parameters
//   Nk  key length in 32-bit words (4, 6 or 8)
//   Nr  number of rounds (Nk+6)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low
//   start       request expansion of key (sampled only in IDLE)
//   key         cipher key, word 0 in the most significant 32 bits
//   busy        high while the schedule is being expanded
//   done        one-cycle pulse when the schedule is complete
//   keys_valid  store holds a complete schedule for the last accepted key
//   rk_idx      round-key read index 0..Nr
//   rk_data     round key rk_idx (combinational read, 0 when rk_idx > Nr)
//
// Optional feature (macro KEYSCHED_STREAM_EN)
//   rk_stream_valid / rk_stream_idx / rk_stream: each round key is pushed out
//   once, in order, on the cycle after its last word has been written.
// -----------------------------------------------------------------------------
module key_schedule_sequencer #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [32*Nk-1:0]    key,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [3:0]          rk_idx,
    output logic [127:0]        rk_data
`ifdef KEYSCHED_STREAM_EN
    ,
    output logic                rk_stream_valid,
    output logic [3:0]          rk_stream_idx,
    output logic [127:0]        rk_stream
`endif
);

    localparam int         NW     = 4 * (Nr + 1);
    localparam logic [5:0] NK_W   = 6'(Nk);
    localparam logic [5:0] LAST_W = 6'(4 * Nr + 3);
    localparam logic [3:0] NR_W   = 4'(Nr);
    localparam logic [2:0] NK_M1  = 3'(Nk - 1);
    localparam bit         IS_NK8 = (Nk == 8);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // ---------------------------------------------------------------- helpers
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    // AES S-box: field inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // ------------------------------------------------------------------ state
    state_t      state_r;
    logic [31:0] w_r [0:NW-1];
    logic [5:0]  cnt_r;
    logic [2:0]  phase_r;      // cnt_r mod Nk, tracked incrementally
    logic [7:0]  rcon_r;

    logic [5:0]  idx_prev_s;
    logic [5:0]  idx_back_s;
    logic [31:0] prev_s;
    logic [31:0] back_s;
    logic [31:0] sub_in_s;
    logic [31:0] sub_s;
    logic [31:0] t_s;
    logic [31:0] new_word_s;

    logic [5:0]  rd_base_s;

    assign idx_prev_s = cnt_r - 6'd1;
    assign idx_back_s = cnt_r - NK_W;
    assign rd_base_s  = {rk_idx, 2'b00};

    // Single shared SubWord datapath; RotWord is applied only at the Nk boundary.
    always_comb begin
        prev_s   = w_r[idx_prev_s];
        back_s   = w_r[idx_back_s];
        sub_in_s = (phase_r == 3'd0) ? rot_word(prev_s) : prev_s;
        sub_s    = sub_word(sub_in_s);
        if (phase_r == 3'd0) begin
            t_s = sub_s ^ {rcon_r, 24'h000000};
        end else if (IS_NK8 && (phase_r == 3'd4)) begin
            t_s = sub_s;
        end else begin
            t_s = prev_s;
        end
        new_word_s = back_s ^ t_s;
    end

    // Round-key read port; indices past the last round read as zero.
    always_comb begin
        if (rk_idx <= NR_W) begin
            rk_data = {w_r[rd_base_s], w_r[rd_base_s + 6'd1],
                       w_r[rd_base_s + 6'd2], w_r[rd_base_s + 6'd3]};
        end else begin
            rk_data = 128'h0;
        end
    end

`ifdef KEYSCHED_STREAM_EN
    logic [3:0]   em_r;        // next round to emit
    logic [5:0]   em_base_s;
    logic [5:0]   em_last_s;
    logic [127:0] em_data_s;

    assign em_base_s = {em_r, 2'b00};
    assign em_last_s = {em_r, 2'b11};

    // Stream data; the round's last word may be the one being written this edge.
    always_comb begin
        if (em_last_s == cnt_r) begin
            em_data_s = {w_r[em_base_s], w_r[em_base_s + 6'd1],
                         w_r[em_base_s + 6'd2], new_word_s};
        end else begin
            em_data_s = {w_r[em_base_s], w_r[em_base_s + 6'd1],
                         w_r[em_base_s + 6'd2], w_r[em_base_s + 6'd3]};
        end
    end
`endif

    // Control FSM, word store and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            cnt_r      <= 6'd0;
            phase_r    <= 3'd0;
            rcon_r     <= 8'h00;
            for (int i = 0; i < NW; i++) begin
                w_r[i] <= 32'h0;
            end
`ifdef KEYSCHED_STREAM_EN
            em_r            <= 4'd0;
            rk_stream_valid <= 1'b0;
            rk_stream_idx   <= 4'd0;
            rk_stream       <= 128'h0;
`endif
        end else begin
            done <= 1'b0;
`ifdef KEYSCHED_STREAM_EN
            rk_stream_valid <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < Nk; i++) begin
                            w_r[i] <= key[32*Nk-1-32*i -: 32];
                        end
                        cnt_r      <= NK_W;
                        phase_r    <= 3'd0;
                        rcon_r     <= 8'h01;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= EXPAND;
`ifdef KEYSCHED_STREAM_EN
                        // Round 0 is entirely key material: emit it right away.
                        rk_stream_valid <= 1'b1;
                        rk_stream_idx   <= 4'd0;
                        rk_stream       <= key[32*Nk-1 -: 128];
                        em_r            <= 4'd1;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXPAND: begin
                    w_r[cnt_r] <= new_word_s;
                    if (phase_r == 3'd0) begin
                        rcon_r <= xtime(rcon_r);
                    end else begin
                        rcon_r <= rcon_r;
                    end
                    if (phase_r == NK_M1) begin
                        phase_r <= 3'd0;
                    end else begin
                        phase_r <= phase_r + 3'd1;
                    end
                    if (cnt_r == LAST_W) begin
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
`ifdef KEYSCHED_STREAM_EN
                    // Emit once the round's last word exists (now or earlier).
                    if ((em_last_s <= cnt_r) && (em_r <= NR_W)) begin
                        rk_stream_valid <= 1'b1;
                        rk_stream_idx   <= em_r;
                        rk_stream       <= em_data_s;
                        em_r            <= em_r + 4'd1;
                    end else begin
                        em_r <= em_r;
                    end
`endif
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Self-checking bench: three instances (Nk = 4, 6, 8), expected round keys
// queued when a key is started and compared once the schedule completes.
module tb_key_schedule_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   rk_idx;
    logic         start4, start6, start8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic         busy4, busy6, busy8;
    logic         done4, done6, done8;
    logic         kv4, kv6, kv8;
    logic [127:0] rk4, rk6, rk8;

    localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK4_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK4_2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] RK4_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

`ifdef KEYSCHED_STREAM_EN
    logic         sv4;
    logic [3:0]   sidx4;
    logic [127:0] sdat4;
    logic         sv6, sv8;
    logic [3:0]   sidx6, sidx8;
    logic [127:0] sdat6, sdat8;
`endif

    key_schedule_sequencer #(.Nk(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .key(key4), .busy(busy4), .done(done4),
        .keys_valid(kv4), .rk_idx(rk_idx), .rk_data(rk4)
`ifdef KEYSCHED_STREAM_EN
        , .rk_stream_valid(sv4), .rk_stream_idx(sidx4), .rk_stream(sdat4)
`endif
    );
    key_schedule_sequencer #(.Nk(6)) u6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .key(key6), .busy(busy6), .done(done6),
        .keys_valid(kv6), .rk_idx(rk_idx), .rk_data(rk6)
`ifdef KEYSCHED_STREAM_EN
        , .rk_stream_valid(sv6), .rk_stream_idx(sidx6), .rk_stream(sdat6)
`endif
    );
    key_schedule_sequencer #(.Nk(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .key(key8), .busy(busy8), .done(done8),
        .keys_valid(kv8), .rk_idx(rk_idx), .rk_data(rk8)
`ifdef KEYSCHED_STREAM_EN
        , .rk_stream_valid(sv8), .rk_stream_idx(sidx8), .rk_stream(sdat8)
`endif
    );

    typedef struct {
        string        tag;
        logic [3:0]   idx;
        logic [127:0] val;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_nk   = 4;

    logic         sel_busy, sel_done, sel_kv;
    logic [127:0] sel_rk;

    always_comb begin
        case (cur_nk)
            6:       begin sel_busy = busy6; sel_done = done6; sel_kv = kv6; sel_rk = rk6; end
            8:       begin sel_busy = busy8; sel_done = done8; sel_kv = kv8; sel_rk = rk8; end
            default: begin sel_busy = busy4; sel_done = done4; sel_kv = kv4; sel_rk = rk4; end
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] idx, input logic [127:0] val);
        exp_t e;
        e.tag = tag;
        e.idx = idx;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Pop every queued expectation and compare against the read port.
    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rk_idx = e.idx;
            #1;
            check(e.tag, sel_rk, e.val);
        end
    endtask

`ifdef KEYSCHED_STREAM_EN
    int stream_exp = 0;
    int stream_cnt = 0;

    // Stream monitor for the Nk=4 instance.
    always @(negedge clk) begin
        if (rst_n && sv4) begin
            check("stream_idx", 128'(sidx4), 128'(stream_exp));
            if (sidx4 == 4'd0) check("stream_r0", sdat4, K4[255:128]);
            if (sidx4 == 4'd1) check("stream_r1", sdat4, RK4_1);
            if (sidx4 == 4'd10) begin
                check("stream_r10", sdat4, RK4_10);
                check("stream_done", 128'(done4), 128'(1));
            end
            stream_exp++;
            stream_cnt++;
        end
    end
`endif

    // mode 0: plain run; 1: start pulses during and at the end of expansion;
    // 2: reset asserted 17 cycles into the expansion.
    task automatic do_run(input int nk, input logic [255:0] k, input int exp_lat, input int mode);
        int lat;
        int extra;
        lat = -1;
        cur_nk = nk;
        @(negedge clk);
        if (nk == 4) begin
            key4 = k[255:128];
            start4 = 1'b1;
`ifdef KEYSCHED_STREAM_EN
            stream_exp = 0;
            stream_cnt = 0;
`endif
        end else if (nk == 6) begin
            key6 = k[255:64];
            start6 = 1'b1;
        end else begin
            key8 = k;
            start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        check("busy_on", 128'(sel_busy), 128'(1));
        check("kv_drop", 128'(sel_kv), 128'(0));
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            start4 = 1'b0;
            if (sel_done) begin
                lat = c;
                break;
            end
            if (mode == 1 && (c == 5 || c == 20 || c == exp_lat - 1)) begin
                key4 = '1;
                start4 = 1'b1;
            end
            if (mode == 2 && c == 17) begin
                rst_n = 1'b0;
                rk_idx = 4'd1;
                #1;
                check("rst_busy", 128'(sel_busy), 128'(0));
                check("rst_done", 128'(sel_done), 128'(0));
                check("rst_kv", 128'(sel_kv), 128'(0));
                check("rst_rk", sel_rk, 128'h0);
                break;
            end
        end
        if (mode == 2) begin
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            check("latency", 128'(lat), 128'(exp_lat));
            check("busy_off", 128'(sel_busy), 128'(0));
            check("kv_set", 128'(sel_kv), 128'(1));
            @(posedge clk);
            #1;
            check("done_pulse", 128'(sel_done), 128'(0));
            if (mode == 1) begin
                extra = 0;
                repeat (50) begin
                    @(posedge clk);
                    #1;
                    if (sel_done) extra++;
                end
                check("extra_done", 128'(extra), 128'(0));
                check("idle_busy", 128'(sel_busy), 128'(0));
                check("idle_kv", 128'(sel_kv), 128'(1));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        key4 = '0; key6 = '0; key8 = '0;
        rk_idx = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 128'(busy4), 128'(0));
        check("reset_done", 128'(done4), 128'(0));
        check("reset_kv", 128'(kv4), 128'(0));
        check("reset_rk", rk4, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // AES-128 reference vector
        push("k4_rk0", 4'd0, K4[255:128]);
        push("k4_rk1", 4'd1, RK4_1);
        push("k4_rk2", 4'd2, RK4_2);
        push("k4_rk10", 4'd10, RK4_10);
        push("k4_rk11", 4'd11, 128'h0);
        do_run(4, K4, 40, 0);
        drain();
`ifdef KEYSCHED_STREAM_EN
        check("stream_count", 128'(stream_cnt), 128'(11));
`endif

        // AES-192 reference vector
        push("k6_rk0", 4'd0, K6[255:128]);
        push("k6_rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
        push("k6_rk13", 4'd13, 128'h0);
        do_run(6, K6, 46, 0);
        drain();

        // AES-256 reference vector
        push("k8_rk0", 4'd0, K8[255:128]);
        push("k8_rk1", 4'd1, K8[127:0]);
        push("k8_rk14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        push("k8_rk15", 4'd15, 128'h0);
        do_run(8, K8, 52, 0);
        drain();

        // Restart over a valid schedule, with start pulses that must be ignored
        push("ign_rk10", 4'd10, RK4_10);
        push("ign_rk11", 4'd11, 128'h0);
        do_run(4, K4, 40, 1);
        drain();

        // Reset mid-expansion, then a fresh expansion
        do_run(4, K4, 40, 2);
        push("rerun_rk1", 4'd1, RK4_1);
        push("rerun_rk10", 4'd10, RK4_10);
        do_run(4, K4, 40, 0);
        drain();
`ifdef KEYSCHED_STREAM_EN
        check("stream_count2", 128'(stream_cnt), 128'(11));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
